trace_buffer: RTL
=================

// Module: trace_buffer
// PURPOSE
//  Write-side store for per-row wall trace results {side,size,texu}, fed by the ray tracer and read
//  by the row renderer during display. Tracer streams results for rows 0..ROWS-1 in order over a
//  valid/ready handshake. Display reads by row index with fixed 1-cycle latency. Optional double
//  buffering hides tracing of frame N+1 while frame N is displayed.
// PARAMETERS
//  ROWS    480  rows per frame (trace results stored per row)
//  SIZE_W  11   wall size width; 0..2047, matches row renderer size input
//  TEXU_W  6    texture u width, 0..63
//  ROW_W   10   row index width; must satisfy 2**ROW_W >= ROWS
// PORTS
//  clk          in   1       system clock
//  reset        in   1       asynchronous, active-high reset
//  frame_start  in   1       1-cycle pulse at start of each frame (vblank)
//  wr_valid     in   1       tracer result valid
//  wr_ready     out  1       buffer accepts result this cycle
//  wr_side      in   1       wall side of result
//  wr_size      in   SIZE_W  wall size of result
//  wr_texu      in   TEXU_W  texture u of result
//  wr_row       out  ROW_W   row index the next accepted result is written to (tracer casts this ray)
//  fill_done    out  1       all ROWS results of the current fill accepted
//  overrun      out  1       sticky: frame_start arrived before a fill completed
//  rd_row       in   ROW_W   display row to read
//  rd_side      out  1       side for rd_row, 1 cycle after rd_row
//  rd_size      out  SIZE_W  size for rd_row, 1 cycle after rd_row
//  rd_texu      out  TEXU_W  texu for rd_row, 1 cycle after rd_row
// BEHAVIOUR
//  - Reset: state IDLE, wr_ready=0, wr_row=0, fill_done=0, overrun=0, rd_* = 0, front bank=0.
//    Memory contents not reset; reads before first completed fill are undefined but rd_* regs start 0.
//  - FSM IDLE -> FILL on frame_start. FILL: wr_ready=1; a transfer is wr_valid&wr_ready; each
//    transfer writes {side,size,texu} to back bank at wr_row and increments wr_row.
//  - Transfer with wr_row==ROWS-1: next state DONE, wr_ready=0, fill_done=1, wr_row holds ROWS-1.
//  - DONE -> FILL on frame_start: swap banks, wr_row=0, fill_done=0, same cycle effect visible on
//    the cycle after the pulse.
//  - frame_start while FILL (incomplete): overrun<=1 (sticky until reset), NO swap, wr_row=0,
//    remain in FILL (restart fill of the same back bank). A transfer in that same cycle is dropped.
//  - wr_valid while IDLE/DONE: ignored, no write.
//  - Read: rd_* registered from front bank at rd_row; latency exactly 1 clk; rd_row >= ROWS returns 0s.
//  - Bank swap and read in same cycle: read uses the pre-swap front bank.
//  - Reset asserted mid-fill: immediate return to IDLE, partial data discarded logically.
// CONFIGURATION
//  TRACE_BUFFER_DOUBLE_EN defined: two banks (2*ROWS entries), front/back swap as above.
//  Undefined: single bank; writes and reads share it (tearing accepted); frame_start in DONE restarts
//  fill without swap; same-address read/write in one cycle returns OLD data (read-before-write).
//  overrun behaves identically in both builds.
// STRUCTURE
//  - Shared package/header rbz_defs: H_VIEW=640, ROWS, SIZE_W, TEXU_W, ROW_W, packed trace word
//    layout {side,size[10:0],texu[5:0]} = 18 bits.
//  - One sub-module: trace_bank (1W1R sync RAM, registered read, read-before-write), instantiated
//    once or twice per macro. FSM, counters and bank select live in trace_buffer.
// TESTING
//  1 Reset then frame_start; 480 back-to-back transfers (size=row, texu=row%64) -> wr_row 0..479,
//    fill_done=1 after 480th, wr_ready=0.
//  2 After fill 1, frame_start; rd_row=100 -> next cycle rd_size=100, rd_texu=36 (double build);
//    single build gives same after fill.
//  3 frame_start after only 200 transfers -> overrun=1, wr_row=0, front bank unchanged (rd_row=5
//    returns previous frame data).
//  4 wr_valid toggled randomly during fill -> only handshaken beats written, no gaps/duplicates.
//  5 Single build: write row 7 size=9 while rd_row=7 (old size=3) -> rd_size=3, then 9 next read.
//  6 Assert reset at row 250 -> IDLE, wr_ready=0, fill_done=0, overrun=0 immediately.

Source files
------------

// File: rtl/trace_buffer_pkg.sv
// Shared definitions for the trace buffer: frame geometry, trace word layout and FSM states.
// The trace word packs {side, size, texu} into 18 bits.
package trace_buffer_pkg;

  localparam int ROWS    = 480;
  localparam int SIZE_W  = 11;
  localparam int TEXU_W  = 6;
  localparam int ROW_W   = 10;
  localparam int TRACE_W = 1 + SIZE_W + TEXU_W;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  typedef struct packed {
    logic              side;
    logic [SIZE_W-1:0] size;
    logic [TEXU_W-1:0] texu;
  } trace_word_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_DONE
  } state_t;

endpackage

// File: rtl/trace_buffer_if.sv
// Tracer write handshake, frame control/status and display read port of the trace buffer.
// master = tracer/display side, slave = trace_buffer.
interface trace_buffer_if;
  import trace_buffer_pkg::*;

  logic              frame_start;
  logic              wr_valid;
  logic              wr_ready;
  logic              wr_side;
  logic [SIZE_W-1:0] wr_size;
  logic [TEXU_W-1:0] wr_texu;
  logic [ROW_W-1:0]  wr_row;
  logic              fill_done;
  logic              overrun;
  logic [ROW_W-1:0]  rd_row;
  logic              rd_side;
  logic [SIZE_W-1:0] rd_size;
  logic [TEXU_W-1:0] rd_texu;

  modport master (
    output frame_start, wr_valid, wr_side, wr_size, wr_texu, rd_row,
    input  wr_ready, wr_row, fill_done, overrun, rd_side, rd_size, rd_texu
  );

  modport slave (
    input  frame_start, wr_valid, wr_side, wr_size, wr_texu, rd_row,
    output wr_ready, wr_row, fill_done, overrun, rd_side, rd_size, rd_texu
  );

endinterface

// File: rtl/trace_buffer_bank.sv
// One bank of trace storage: 1W1R synchronous RAM with a registered, read-before-write read port.
// Addresses past the last row read back as zero.
module trace_buffer_bank
  import trace_buffer_pkg::*;
#(
  parameter int DEPTH = ROWS,
  parameter int AW    = ROW_W,
  parameter int DW    = TRACE_W
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Same-cycle write to the read address is not forwarded: the old word comes out.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                 r_rdata <= '0;
    else if (i_raddr <= LAST)  r_rdata <= r_mem[i_raddr];
    else                       r_rdata <= '0;
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/trace_buffer.sv
// Per-row wall trace store: fill FSM, write row counter, overrun flag and bank selection.
// Define TRACE_BUFFER_DOUBLE_EN for front/back double buffering; default is a single shared bank.
module trace_buffer
  import trace_buffer_pkg::*;
(
  input  logic           i_clk,
  input  logic           i_rst,
  trace_buffer_if.slave  bus
);

  state_t           r_state, w_state_n;
  logic [ROW_W-1:0] r_wr_row, w_wr_row_n;
  logic             r_overrun, w_overrun_n;
  logic             w_we;
  trace_word_t      w_wdata;
  trace_word_t      w_rdata;

`ifdef TRACE_BUFFER_DOUBLE_EN
  logic             r_front, w_front_n;
  logic             r_rd_sel;
  trace_word_t      w_q0, w_q1;
`endif

  assign w_wdata = {bus.wr_side, bus.wr_size, bus.wr_texu};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_wr_row  <= '0;
      r_overrun <= 1'b0;
`ifdef TRACE_BUFFER_DOUBLE_EN
      r_front   <= 1'b0;
      r_rd_sel  <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_n;
      r_wr_row  <= w_wr_row_n;
      r_overrun <= w_overrun_n;
`ifdef TRACE_BUFFER_DOUBLE_EN
      r_front   <= w_front_n;
      // Captures the pre-swap bank so a read issued on the swap cycle sees the old frame.
      r_rd_sel  <= r_front;
`endif
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_wr_row_n  = r_wr_row;
    w_overrun_n = r_overrun;
    w_we        = 1'b0;
`ifdef TRACE_BUFFER_DOUBLE_EN
    w_front_n   = r_front;
`endif
    case (r_state)
      ST_IDLE: begin
        if (bus.frame_start) begin
          w_state_n  = ST_FILL;
          w_wr_row_n = '0;
        end
      end
      ST_FILL: begin
        // A new frame before the fill completes restarts the same bank; any beat this cycle is lost.
        if (bus.frame_start) begin
          w_overrun_n = 1'b1;
          w_wr_row_n  = '0;
        end else if (bus.wr_valid) begin
          w_we = 1'b1;
          if (r_wr_row == LAST_ROW) w_state_n  = ST_DONE;
          else                      w_wr_row_n = r_wr_row + ROW_W'(1);
        end
      end
      ST_DONE: begin
        if (bus.frame_start) begin
          w_state_n  = ST_FILL;
          w_wr_row_n = '0;
`ifdef TRACE_BUFFER_DOUBLE_EN
          w_front_n  = ~r_front;
`endif
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

`ifdef TRACE_BUFFER_DOUBLE_EN
  // Bank r_front is displayed; the other one is being filled.
  trace_buffer_bank u_bank0 (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (w_we & r_front),
    .i_waddr (r_wr_row),
    .i_wdata (w_wdata),
    .i_raddr (bus.rd_row),
    .o_rdata (w_q0)
  );

  trace_buffer_bank u_bank1 (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (w_we & ~r_front),
    .i_waddr (r_wr_row),
    .i_wdata (w_wdata),
    .i_raddr (bus.rd_row),
    .o_rdata (w_q1)
  );

  assign w_rdata = r_rd_sel ? w_q1 : w_q0;
`else
  trace_buffer_bank u_bank (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (w_we),
    .i_waddr (r_wr_row),
    .i_wdata (w_wdata),
    .i_raddr (bus.rd_row),
    .o_rdata (w_rdata)
  );
`endif

  assign bus.wr_ready  = (r_state == ST_FILL);
  assign bus.fill_done = (r_state == ST_DONE);
  assign bus.wr_row    = r_wr_row;
  assign bus.overrun   = r_overrun;
  assign bus.rd_side   = w_rdata.side;
  assign bus.rd_size   = w_rdata.size;
  assign bus.rd_texu   = w_rdata.texu;

endmodule
